ltl_nfa_monitor: RTL and testbench

Runtime-programmable NFA monitor engine for the `monitorN` clusters: a parametrised successor to the per-property generated automata. Match sets, edges, start states and report states are loaded over a configuration port instead of being fixed in RTL. Supports selectable start mode, symbol-stream backpressure, and a timestamped report FIFO. Sits between the trace symbol encoder and the monitor report collector.

---
 rtl/ltl_nfa_monitor_if.sv | 36 +++
 rtl/ltl_nfa_monitor.sv | 145 ++++++++++++++
 tb/tb_ltl_nfa_monitor.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ltl_nfa_monitor_if.sv
// rtl/ltl_nfa_monitor_if.sv - control, configuration, symbol and report signals of the NFA monitor
interface ltl_nfa_monitor_if #(
    parameter int N_STE = 16,
    parameter int SYM_W = 8,
    parameter int IDX_W = 32
);
    logic               run;
    logic               clear;
    logic               all_input_mode;
    logic               cfg_we;
    logic [1:0]         cfg_sel;
    logic [SYM_W-1:0]   cfg_addr;
    logic [N_STE-1:0]   cfg_wdata;
    logic               sym_valid;
    logic               sym_ready;
    logic [SYM_W-1:0]   sym_data;
    logic [N_STE-1:0]   active;
    logic [IDX_W-1:0]   sym_idx;
    logic               rpt_valid;
    logic               rpt_ready;
    logic [N_STE-1:0]   rpt_vec;
    logic [IDX_W-1:0]   rpt_idx;
    logic [15:0]        rpt_count;

    modport master (
        output run, clear, all_input_mode, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        output sym_valid, sym_data, rpt_ready,
        input  sym_ready, active, sym_idx, rpt_valid, rpt_vec, rpt_idx, rpt_count
    );

    modport slave (
        input  run, clear, all_input_mode, cfg_we, cfg_sel, cfg_addr, cfg_wdata,
        input  sym_valid, sym_data, rpt_ready,
        output sym_ready, active, sym_idx, rpt_valid, rpt_vec, rpt_idx, rpt_count
    );
endinterface

// File: rtl/ltl_nfa_monitor.sv
// rtl/ltl_nfa_monitor.sv - runtime-programmable NFA monitor with timestamped report FIFO
module ltl_nfa_monitor #(
    parameter int N_STE     = 16,
    parameter int SYM_W     = 8,
    parameter int RPT_DEPTH = 8,
    parameter int IDX_W     = 32
) (
    input logic              clk,
    input logic              reset,
    ltl_nfa_monitor_if.slave bus
);
    localparam int STE_W = (N_STE > 1) ? $clog2(N_STE) : 1;
    localparam int PTR_W = $clog2(RPT_DEPTH);
    localparam int N_SYM = 1 << SYM_W;

    logic [N_STE-1:0] r_match [N_SYM];
    logic [N_STE-1:0] r_fanin [N_STE];
    logic [N_STE-1:0] r_start_mask;
    logic [N_STE-1:0] r_report_mask;
    logic [N_STE-1:0] r_active;
    logic             r_first;
    logic [IDX_W-1:0] r_sym_idx;
    logic [15:0]      r_rpt_count;

    logic [N_STE-1:0] r_fifo_vec [RPT_DEPTH];
    logic [IDX_W-1:0] r_fifo_idx [RPT_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_fill;

    logic             w_cfg_en;
    logic             w_fanin_ok;
    logic             w_full;
    logic             w_empty;
    logic             w_acc;
    logic             w_push;
    logic             w_pop;
    logic [N_STE-1:0] w_enable;
    logic [N_STE-1:0] w_active_next;
    logic [N_STE-1:0] w_hit;

    assign w_cfg_en   = bus.cfg_we & ~bus.run & ~reset;
    assign w_fanin_ok = ({1'b0, bus.cfg_addr} < (SYM_W+1)'(N_STE));
    assign w_full     = (r_fill == (PTR_W+1)'(RPT_DEPTH));
    assign w_empty    = (r_fill == '0);

    // Holding off input while full is what guarantees no report is ever dropped.
    assign bus.sym_ready = bus.run & ~bus.clear & ~w_full & ~reset;
    assign w_acc         = bus.sym_valid & bus.sym_ready;
    assign w_pop         = ~w_empty & bus.rpt_ready;

    always_comb begin
        w_enable = '0;
        for (int j = 0; j < N_STE; j++) begin
            w_enable[j] = (|(r_fanin[j] & r_active))
                        | (r_start_mask[j] & (r_first | bus.all_input_mode));
        end
    end

    assign w_active_next = w_enable & r_match[bus.sym_data];
    assign w_hit         = w_active_next & r_report_mask;
    assign w_push        = w_acc & (|w_hit);

    // Match table is left unreset so it can map onto a plain RAM.
    always_ff @(posedge clk) begin
        if (w_cfg_en && bus.cfg_sel == 2'd0) begin
            r_match[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < N_STE; j++) begin
                r_fanin[j] <= '0;
            end
            r_start_mask  <= '0;
            r_report_mask <= '0;
        end else if (w_cfg_en) begin
            case (bus.cfg_sel)
                2'd1: begin
                    if (w_fanin_ok) begin
                        r_fanin[bus.cfg_addr[STE_W-1:0]] <= bus.cfg_wdata;
                    end
                end
                2'd2:    r_start_mask  <= bus.cfg_wdata;
                2'd3:    r_report_mask <= bus.cfg_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_active    <= '0;
            r_first     <= 1'b1;
            r_sym_idx   <= '0;
            r_rpt_count <= '0;
        end else if (bus.clear) begin
            r_active  <= '0;
            r_first   <= 1'b1;
            r_sym_idx <= '0;
        end else if (w_acc) begin
            r_active  <= w_active_next;
            r_first   <= 1'b0;
            r_sym_idx <= r_sym_idx + IDX_W'(1);
            if (w_push && r_rpt_count != 16'hFFFF) begin
                r_rpt_count <= r_rpt_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_vec[r_wr_ptr] <= w_hit;
            r_fifo_idx[r_wr_ptr] <= r_sym_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + (PTR_W+1)'(1);
                2'b01:   r_fill <= r_fill - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    assign bus.active    = r_active;
    assign bus.sym_idx   = r_sym_idx;
    assign bus.rpt_count = r_rpt_count;
    assign bus.rpt_valid = ~w_empty;
    assign bus.rpt_vec   = w_empty ? '0 : r_fifo_vec[r_rd_ptr];
    assign bus.rpt_idx   = w_empty ? '0 : r_fifo_idx[r_rd_ptr];
endmodule

// File: tb/tb_ltl_nfa_monitor.sv
// tb/tb_ltl_nfa_monitor.sv - scoreboard bench for ltl_nfa_monitor against a behavioural NFA model
module tb_ltl_nfa_monitor;
    localparam int N     = 16;
    localparam int IDXW  = 4;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;

    ltl_nfa_monitor_if #(.N_STE(N), .SYM_W(8), .IDX_W(IDXW)) bus ();

    ltl_nfa_monitor #(.N_STE(N), .SYM_W(8), .RPT_DEPTH(DEPTH), .IDX_W(IDXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] vec;
        logic [3:0]  idx;
    } rpt_t;

    int   errors = 0;
    int   checks = 0;
    rpt_t q[$];

    bit m_match [256][16];
    bit m_fanin [16][16];
    bit m_start [16];
    bit m_rep   [16];
    bit m_act   [16];
    bit m_first;
    int m_idx;
    int m_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] vec16(input bit a[16]);
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = a[i];
        return v;
    endfunction

    function automatic bit exp_ready();
        return bus.run && !bus.clear && (q.size() < DEPTH);
    endfunction

    task automatic model_accept(input logic [7:0] s);
        bit          nxt [16];
        logic [15:0] hit;
        hit = '0;
        for (int j = 0; j < 16; j++) begin
            bit en;
            en = m_start[j] && (m_first || bus.all_input_mode);
            for (int i = 0; i < 16; i++)
                if (m_fanin[j][i] && m_act[i]) en = 1;
            nxt[j] = en && m_match[s][j];
            if (nxt[j] && m_rep[j]) hit[j] = 1'b1;
        end
        if (hit != 0) begin
            q.push_back('{hit, 4'(m_idx)});
            if (m_cnt < 65535) m_cnt++;
        end
        m_act   = nxt;
        m_first = 0;
        m_idx   = (m_idx + 1) % 16;
    endtask

    always @(negedge clk) begin
        #2;
        if (!reset && !bus.clear && bus.rpt_valid && bus.rpt_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_report: got vec %0h idx %0h expected none", bus.rpt_vec, bus.rpt_idx);
            end else begin
                rpt_t e;
                e = q.pop_front();
                chk("rpt_vec", bus.rpt_vec, e.vec);
                chk("rpt_idx", bus.rpt_idx, e.idx);
            end
        end
    end

    task automatic cfg(input int sel, input int addr, input logic [15:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_sel   = sel[1:0];
        bus.cfg_addr  = addr[7:0];
        bus.cfg_wdata = data;
        if (!bus.run) begin
            for (int i = 0; i < 16; i++) begin
                case (sel)
                    0: m_match[addr][i] = data[i];
                    1: if (addr < N) m_fanin[addr][i] = data[i];
                    2: m_start[i] = data[i];
                    default: m_rep[i] = data[i];
                endcase
            end
        end
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        for (int i = 0; i < 16; i++) m_act[i] = 0;
        m_first = 1;
        m_idx   = 0;
        q.delete();
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic send(input logic [7:0] s, input bit rnd_ready);
        bit done;
        done          = 0;
        bus.sym_valid = 1'b1;
        bus.sym_data  = s;
        for (int t = 0; t < 64 && !done; t++) begin
            if (rnd_ready) bus.rpt_ready = 1'($urandom_range(0, 1));
            #1;
            chk("sym_ready", bus.sym_ready, exp_ready());
            if (bus.sym_ready) begin
                model_accept(s);
                done = 1;
            end
            @(negedge clk);
            if (done) begin
                chk("active", bus.active, vec16(m_act));
                chk("sym_idx", bus.sym_idx, 32'(m_idx));
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: symbol %0h not accepted, required acceptance", s);
        end
        bus.sym_valid = 1'b0;
    endtask

    task automatic idle(input bit rnd_ready);
        bus.sym_valid = 1'b0;
        if (rnd_ready) bus.rpt_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
    endtask

    task automatic drain();
        bus.rpt_ready = 1'b1;
        for (int t = 0; t < 40 && q.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        #1;
        chk("pending_reports", q.size(), 0);
        chk("rpt_valid_drained", bus.rpt_valid, 1'b0);
        chk("rpt_count", bus.rpt_count, m_cnt);
    endtask

    task automatic chain();
        send(8'h41, 0);
        send(8'h42, 0);
        send(8'h43, 0);
    endtask

    initial begin
        reset              = 1'b1;
        bus.run            = 1'b1;
        bus.clear          = 1'b0;
        bus.all_input_mode = 1'b0;
        bus.cfg_we         = 1'b0;
        bus.cfg_sel        = 2'd0;
        bus.cfg_addr       = '0;
        bus.cfg_wdata      = '0;
        bus.sym_valid      = 1'b0;
        bus.sym_data       = '0;
        bus.rpt_ready      = 1'b0;
        m_first = 1;
        m_idx   = 0;
        m_cnt   = 0;

        @(negedge clk);
        @(negedge clk);
        chk("ready_in_reset", bus.sym_ready, 1'b0);
        reset   = 1'b0;
        bus.run = 1'b0;
        #1;
        chk("reset_active", bus.active, 0);
        chk("reset_sym_idx", bus.sym_idx, 0);
        chk("reset_rpt_valid", bus.rpt_valid, 0);
        chk("reset_rpt_vec", bus.rpt_vec, 0);
        chk("reset_rpt_idx", bus.rpt_idx, 0);
        chk("reset_rpt_count", bus.rpt_count, 0);
        @(negedge clk);

        for (int s = 0; s < 256; s++) cfg(0, s, 16'h0000);
        cfg(0, 8'h41, 16'h0001);
        cfg(0, 8'h42, 16'h0002);
        cfg(0, 8'h43, 16'h0004);
        cfg(1, 1, 16'h0001);
        cfg(1, 2, 16'h0002);
        cfg(2, 0, 16'h0001);
        cfg(3, 0, 16'h0004);

        bus.run       = 1'b1;
        bus.rpt_ready = 1'b1;
        chain();
        drain();

        do_clear();
        send(8'h00, 0);
        chain();
        drain();
        bus.all_input_mode = 1'b1;
        do_clear();
        send(8'h00, 0);
        chain();
        drain();
        bus.all_input_mode = 1'b0;

        do_clear();
        send(8'h41, 0);
        send(8'h42, 0);
        do_clear();
        #1;
        chk("clear_active", bus.active, 0);
        chk("clear_sym_idx", bus.sym_idx, 0);
        @(negedge clk);
        send(8'h43, 0);
        chain();
        drain();

        cfg(3, 0, 16'h0000);
        do_clear();
        chain();
        drain();

        bus.run = 1'b0;
        for (int s = 0; s < 8; s++) cfg(0, s, 16'h0001);
        cfg(1, 0, 16'h0001);
        cfg(3, 0, 16'h0001);
        bus.run = 1'b1;
        do_clear();
        bus.rpt_ready = 1'b0;
        for (int k = 0; k < 8; k++) send(8'h05, 0);
        bus.sym_valid = 1'b1;
        bus.sym_data  = 8'h05;
        #1;
        chk("ready_when_full", bus.sym_ready, 1'b0);
        @(negedge clk);
        bus.rpt_ready = 1'b1;
        #1;
        chk("ready_full_popping", bus.sym_ready, 1'b0);
        @(negedge clk);
        bus.rpt_ready = 1'b0;
        send(8'h05, 0);
        drain();

        do_clear();
        for (int k = 0; k < 17; k++) send(8'($urandom_range(0, 255)), 0);
        chk("sym_idx_wrap", bus.sym_idx, 1);
        drain();

        for (int round = 0; round < 3; round++) begin
            bus.run = 1'b0;
            for (int s = 0; s < 16; s++) cfg(0, s, 16'($urandom));
            for (int j = 0; j < N; j++) cfg(1, j, 16'($urandom) & 16'($urandom));
            cfg(1, 200, 16'hFFFF);
            cfg(2, 0, 16'($urandom));
            cfg(3, 0, 16'($urandom));
            bus.all_input_mode = 1'($urandom_range(0, 1));
            bus.run = 1'b1;
            do_clear();
            for (int k = 0; k < 120; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                send(8'($urandom_range(0, 15)), 1);
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
